// File: rtl/mem_req_scheduler.sv
// Arbitrates NUM_REQ packet requesters onto a single memory port and returns read responses as packets.
// Latency: grant pulse -> mem_valid 1 cycle; mem_rvalid -> out_valid 1 cycle; all outputs registered.
// Backpressure: mem_valid held until mem_ready, out_valid held until out_ready; no new grant while a transaction is open.
module mem_req_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int DATA_WIDTH       = 18,
  parameter int WIDTH            = 4,
  parameter int VALID_DATA_WIDTH = 8,
  parameter int MEM_INDEX        = 0,
  parameter int FILTER_NUM       = 5,
  parameter int IFMAP_NUM        = 7,
  parameter int DEPTH_R          = 3,
  parameter int WIDTH_R          = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            filt_loaded,
  input  logic                            ifmap_loaded,
  output logic                            mem_valid,
  output logic [1:0]                      mem_type,
  output logic [VALID_DATA_WIDTH-1:0]     mem_addr,
  output logic [VALID_DATA_WIDTH-1:0]     mem_wdata,
  input  logic                            mem_ready,
  input  logic                            mem_rvalid,
  input  logic [VALID_DATA_WIDTH-1:0]     mem_rdata,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  input  logic                            out_ready,
  output logic                            done,
  output logic                            err,
  output logic [7:0]                      err_cnt
);

  localparam int VDW   = VALID_DATA_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] T_WR  = 2'b00;
  localparam logic [1:0] T_IF  = 2'b01;
  localparam logic [1:0] T_FL  = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;

  localparam logic [VDW-1:0] IF_LIM    = VDW'(IFMAP_NUM * IFMAP_NUM);
  localparam logic [VDW-1:0] FL_LIM    = VDW'(FILTER_NUM * FILTER_NUM);
  localparam logic [7:0]     RES_TOTAL = 8'(DEPTH_R * WIDTH_R);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [DATA_WIDTH-1:0] pkt_q, pkt_d;
  logic [7:0]            result_cnt_q, result_cnt_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  done_q, done_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [1:0]            mem_type_q, mem_type_d;
  logic [VDW-1:0]        mem_addr_q, mem_addr_d;
  logic [VDW-1:0]        mem_wdata_q, mem_wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0] req_pkt [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic                  gnt_vld;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand;

  // Fields of the captured packet; destination is carried but never acted on.
  logic [1:0]       pkt_type;
  logic [WIDTH-1:0] pkt_src;
  logic [VDW-1:0]   pkt_field;
  logic             pkt_drop;
  logic             unused_dest;

  assign pkt_type    = pkt_q[DATA_WIDTH-1 -: 2];
  assign pkt_src     = pkt_q[VDW+2*WIDTH-1 -: WIDTH];
  assign pkt_field   = pkt_q[VDW-1:0];
  assign unused_dest = ^pkt_q[VDW+WIDTH-1 -: WIDTH];
  assign pkt_drop    = (pkt_type == T_BAD) ||
                       ((pkt_type == T_IF) && (pkt_field >= IF_LIM)) ||
                       ((pkt_type == T_FL) && (pkt_field >= FL_LIM));

  // Split the flat request bus and mark requesters whose packet may be served now (reads wait for both stores).
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pkt[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      elig[i]    = req_valid[i] &&
                   ((req_pkt[i][DATA_WIDTH-1 -: 2] == T_WR) ||
                    (req_pkt[i][DATA_WIDTH-1 -: 2] == T_BAD) ||
                    (filt_loaded && ifmap_loaded));
    end
  end

  // Round-robin pick: first eligible requester at or after rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Next-state logic. ARB spends one cycle deciding and one cycle presenting the grant pulse,
  // so the command reaches the memory port exactly one cycle after the pulse.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready_d  = '0;
    pkt_d        = pkt_q;
    result_cnt_d = result_cnt_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    done_d       = done_q;
    mem_valid_d  = mem_valid_q;
    mem_type_d   = mem_type_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    case (state_q)
      S_IDLE: state_d = S_ARB;
      S_ARB: begin
        if (req_ready_q == '0) begin
          if (gnt_vld) begin
            req_ready_d = NUM_REQ'(1) << gnt_idx;
            pkt_d       = req_pkt[gnt_idx];
            rr_ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          end
        end else if (pkt_drop) begin
          err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          // Results land at consecutive addresses indexed by the result counter.
          mem_valid_d = 1'b1;
          mem_type_d  = pkt_type;
          mem_addr_d  = (pkt_type == T_WR) ? VDW'(result_cnt_q) : pkt_field;
          mem_wdata_d = (pkt_type == T_WR) ? pkt_field : '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_type_q == T_WR) begin
            result_cnt_d = result_cnt_q + 8'd1;
            if (result_cnt_d == RES_TOTAL) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ARB;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_data_d  = {pkt_type, WIDTH'(MEM_INDEX), pkt_src, mem_rdata};
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ARB;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; synchronous reset abandons any open transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      req_ready_q  <= '0;
      pkt_q        <= '0;
      result_cnt_q <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      done_q       <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_type_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      req_ready_q  <= req_ready_d;
      pkt_q        <= pkt_d;
      result_cnt_q <= result_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      done_q       <= done_d;
      mem_valid_q  <= mem_valid_d;
      mem_type_q   <= mem_type_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_type  = mem_type_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 SHALL have parameters: NUM_REQ=4, number of requester ports; DATA_WIDTH=18, packet width; WIDTH=4, node-index width; VALID_DATA_WIDTH=8, address/data width; MEM_INDEX=0, memory node index placed in response packets; FILTER_NUM=5; IFMAP_NUM=7; DEPTH_R=3; WIDTH_R=3.
REQ-002 SHALL have ports: clk in 1, sole clock; rst_n in 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have ports: req_valid in NUM_REQ, per-requester request valid; req_data in NUM_REQ*DATA_WIDTH, packet i at bits [i*DATA_WIDTH +: DATA_WIDTH]; req_ready out NUM_REQ, one-hot one-cycle accept pulse.
REQ-004 SHALL have ports: filt_loaded in 1, filter store complete; ifmap_loaded in 1, ifmap store complete.
REQ-005 SHALL have ports: mem_valid out 1; mem_type out 2; mem_addr out VALID_DATA_WIDTH; mem_wdata out VALID_DATA_WIDTH; mem_ready in 1, memory accepts the command.
REQ-006 SHALL have ports: mem_rvalid in 1; mem_rdata in VALID_DATA_WIDTH, read return data.
REQ-007 SHALL have ports: out_valid out 1; out_data out DATA_WIDTH, response packet; out_ready in 1.
REQ-008 SHALL have ports: done out 1, all results written; err out 1, sticky error; err_cnt out 8, count of dropped packets.

Function
REQ-009 SHALL decode each packet as: [17:16] type (01 ifmap read, 10 filter read, 00 result write, 11 illegal); [15:12] source index; [11:8] destination; [7:0] address for reads, or result value for writes.
REQ-010 SHALL use FSM states IDLE, ARB, ISSUE, WAIT_RSP, SEND_RSP, DONE; reset state IDLE, which moves to ARB on the next cycle.
REQ-011 SHALL, in ARB, treat requester i as eligible if req_valid[i]=1 and either its type is 00 or 11, or filt_loaded and ifmap_loaded are both 1.
REQ-012 SHALL, in ARB, select among eligible requesters round-robin, starting from rr_ptr (reset 0); after a grant to i, rr_ptr becomes (i+1) mod NUM_REQ.
REQ-013 SHALL, on a grant, pulse req_ready[i] for exactly that ARB cycle and capture type, source and field in the same cycle.
REQ-014 SHALL stay in ARB with all req_ready=0 when no requester is eligible; ineligible reads are skipped without moving rr_ptr.
REQ-015 SHALL drop a granted packet and return to ARB if it is type 11, an ifmap read with addr >= IFMAP_NUM*IFMAP_NUM, or a filter read with addr >= FILTER_NUM*FILTER_NUM; each drop sets err=1 and increments err_cnt, saturating at 255.
REQ-016 SHALL otherwise go to ISSUE, holding mem_valid=1 with mem_type, mem_addr and mem_wdata stable until the cycle mem_ready=1.
REQ-017 SHALL set mem_wdata = field for writes and mem_wdata = 0 for reads.
REQ-018 SHALL make grant-to-mem_valid latency exactly 1 cycle.
REQ-019 SHALL, on write acceptance, increment result_cnt and go to ARB, or go to DONE if result_cnt reaches DEPTH_R*WIDTH_R.
REQ-020 SHALL, on read acceptance, go to WAIT_RSP; on mem_rvalid=1, latch mem_rdata and go to SEND_RSP.
REQ-021 SHALL, in SEND_RSP, hold out_valid=1 with out_data = {type, MEM_INDEX, captured source, rdata} until out_ready=1, then go to ARB.
REQ-022 SHALL ignore mem_rvalid outside WAIT_RSP.
REQ-023 SHALL allow only one outstanding memory transaction at a time.
REQ-024 SHALL, in DONE, hold done=1 and mem_valid=0, grant nothing and keep all req_ready=0; DONE is left only by reset.
REQ-025 SHALL drive outputs from registers only, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, set state=IDLE, rr_ptr=0, result_cnt=0, err_cnt=0, and drive err, done, mem_valid, out_valid and req_ready to 0, with mem_type/mem_addr/mem_wdata/out_data all 0.
REQ-027 SHALL treat reset mid-transaction (ISSUE/WAIT_RSP/SEND_RSP) as abandoning the transaction, with no response emitted afterwards.

Verification
REQ-028 SHALL cover: loaded=1/1; req 0 sends 0x1_0_3_05 (ifmap, src 0, addr 5); mem_rdata=0x2A -> mem_valid 1 cycle after grant with type 01, addr 5; out_data = {01, 0, 0, 0x2A}.
REQ-029 SHALL cover: loaded=0/0; req 1 filter read and req 2 write of 0x07 -> req 2 granted and write issued; req 1 granted only after both loaded flags rise.
REQ-030 SHALL cover: all 4 requesters hold writes valid -> grant order 0,1,2,3,0 and result_cnt increments by 1 per write.
REQ-031 SHALL cover: 9 accepted writes -> done=1 after the 9th mem_ready; further requests get no req_ready.
REQ-032 SHALL cover: filter read addr 25, then type-11 packet -> both dropped, no mem_valid, err=1, err_cnt=2.
REQ-033 SHALL cover: out_ready=0 for 5 cycles in SEND_RSP -> out_data stable and no new grant; rst_n=0 in WAIT_RSP -> all outputs 0 next cycle.
